// File: rtl/sal_cmd_sched.sv
// sal_cmd_sched: inter-bank DRAM command scheduler.
// Picks at most one bank command per cycle with class priority
// REF > PRE > CAS(RD/WR) > ACT, round-robin inside each class, and gates
// ACT/RD/WR on the shared tRRD/tCCD/tWTR/tRTW down-counters.
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 2
`endif
`ifndef DRAM_RA_WIDTH
`define DRAM_RA_WIDTH 14
`endif
`ifndef DRAM_CA_WIDTH
`define DRAM_CA_WIDTH 10
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef T_RRD_WIDTH
`define T_RRD_WIDTH 4
`endif
`ifndef T_CCD_WIDTH
`define T_CCD_WIDTH 4
`endif
`ifndef T_WTR_WIDTH
`define T_WTR_WIDTH 4
`endif
`ifndef T_RTW_WIDTH
`define T_RTW_WIDTH 4
`endif

module sal_cmd_sched #(
    parameter int NUM_BANKS = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_BANKS-1:0]                  act_req,
    input  logic [NUM_BANKS-1:0]                  rd_req,
    input  logic [NUM_BANKS-1:0]                  wr_req,
    input  logic [NUM_BANKS-1:0]                  pre_req,
    input  logic [NUM_BANKS-1:0]                  ref_req,
    input  logic [NUM_BANKS*`DRAM_RA_WIDTH-1:0]   ra,
    input  logic [NUM_BANKS*`DRAM_CA_WIDTH-1:0]   ca,
    input  logic [NUM_BANKS*`AXI_ID_WIDTH-1:0]    id,
    input  logic [NUM_BANKS*`AXI_LEN_WIDTH-1:0]   len,
    output logic [NUM_BANKS-1:0]                  act_gnt,
    output logic [NUM_BANKS-1:0]                  rd_gnt,
    output logic [NUM_BANKS-1:0]                  wr_gnt,
    output logic [NUM_BANKS-1:0]                  pre_gnt,
    output logic [NUM_BANKS-1:0]                  ref_gnt,
    input  logic [`T_RRD_WIDTH-1:0]               t_rrd_m1,
    input  logic [`T_CCD_WIDTH-1:0]               t_ccd_m1,
    input  logic [`T_WTR_WIDTH-1:0]               t_wtr_m1,
    input  logic [`T_RTW_WIDTH-1:0]               t_rtw_m1,
    output logic                                  cmd_valid,
    output logic [2:0]                            cmd_type,
    output logic [`DRAM_BA_WIDTH-1:0]             cmd_ba,
    output logic [`DRAM_RA_WIDTH-1:0]             cmd_ra,
    output logic [`DRAM_CA_WIDTH-1:0]             cmd_ca,
    output logic [`AXI_ID_WIDTH-1:0]              cmd_id,
    output logic [`AXI_LEN_WIDTH-1:0]             cmd_len
);
    localparam int BA_W  = `DRAM_BA_WIDTH;
    localparam int RA_W  = `DRAM_RA_WIDTH;
    localparam int CA_W  = `DRAM_CA_WIDTH;
    localparam int ID_W  = `AXI_ID_WIDTH;
    localparam int LEN_W = `AXI_LEN_WIDTH;

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    logic [`T_RRD_WIDTH-1:0] rrd_cnt;
    logic [`T_CCD_WIDTH-1:0] ccd_cnt;
    logic [`T_WTR_WIDTH-1:0] wtr_cnt;
    logic [`T_RTW_WIDTH-1:0] rtw_cnt;
    logic [BA_W-1:0]         ptr_ref, ptr_pre, ptr_cas, ptr_act;

    logic [NUM_BANKS-1:0]    rd_elig, wr_elig, act_elig, cas_elig;
    logic [BA_W:0]           pick_ref, pick_pre, pick_cas, pick_act;
    logic [2:0]              sel_type;
    logic [BA_W-1:0]         sel_bank;

    // Round-robin search starting at ptr; returns {found, bank}. Bank
    // count is a power of two, so the BA_W-bit add wraps naturally.
    function automatic logic [BA_W:0] rr_pick(input logic [NUM_BANKS-1:0] vec,
                                              input logic [BA_W-1:0] ptr);
        logic [BA_W-1:0] cand;
        logic [BA_W:0]   res;
        res = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            cand = ptr + BA_W'(i);
            if (vec[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

    // Saturating decrement shared by all timing counters.
    function automatic int unsigned sat_dec(input int unsigned v);
        return (v == 0) ? 0 : v - 1;
    endfunction

    // Eligibility, class-priority arbitration and one-hot grant generation.
    always_comb begin
        act_gnt  = '0;
        rd_gnt   = '0;
        wr_gnt   = '0;
        pre_gnt  = '0;
        ref_gnt  = '0;
        sel_type = CMD_NOP;
        sel_bank = '0;
        rd_elig  = rd_req & {NUM_BANKS{(ccd_cnt == 0) && (wtr_cnt == 0)}};
        wr_elig  = wr_req & {NUM_BANKS{(ccd_cnt == 0) && (rtw_cnt == 0)}};
        act_elig = act_req & {NUM_BANKS{rrd_cnt == 0}};
        cas_elig = rd_elig | wr_elig;
        pick_ref = rr_pick(ref_req, ptr_ref);
        pick_pre = rr_pick(pre_req, ptr_pre);
        pick_cas = rr_pick(cas_elig, ptr_cas);
        pick_act = rr_pick(act_elig, ptr_act);
        if (!rst) begin
            if (pick_ref[BA_W]) begin
                sel_bank = pick_ref[BA_W-1:0];
                sel_type = CMD_REF;
                ref_gnt[sel_bank] = 1'b1;
            end else if (pick_pre[BA_W]) begin
                sel_bank = pick_pre[BA_W-1:0];
                sel_type = CMD_PRE;
                pre_gnt[sel_bank] = 1'b1;
            end else if (pick_cas[BA_W]) begin
                // A bank offering both RD and WR gets its RD first.
                sel_bank = pick_cas[BA_W-1:0];
                if (rd_elig[sel_bank]) begin
                    sel_type = CMD_RD;
                    rd_gnt[sel_bank] = 1'b1;
                end else begin
                    sel_type = CMD_WR;
                    wr_gnt[sel_bank] = 1'b1;
                end
            end else if (pick_act[BA_W]) begin
                sel_bank = pick_act[BA_W-1:0];
                sel_type = CMD_ACT;
                act_gnt[sel_bank] = 1'b1;
            end
        end
    end

    // Inter-bank timing counters: load on grant, otherwise count down to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rrd_cnt <= '0;
            ccd_cnt <= '0;
            wtr_cnt <= '0;
            rtw_cnt <= '0;
        end else begin
            rrd_cnt <= (sel_type == CMD_ACT) ? t_rrd_m1
                     : `T_RRD_WIDTH'(sat_dec(32'(rrd_cnt)));
            ccd_cnt <= (sel_type == CMD_RD || sel_type == CMD_WR) ? t_ccd_m1
                     : `T_CCD_WIDTH'(sat_dec(32'(ccd_cnt)));
            wtr_cnt <= (sel_type == CMD_WR) ? t_wtr_m1
                     : `T_WTR_WIDTH'(sat_dec(32'(wtr_cnt)));
            rtw_cnt <= (sel_type == CMD_RD) ? t_rtw_m1
                     : `T_RTW_WIDTH'(sat_dec(32'(rtw_cnt)));
        end
    end

    // Round-robin pointers: the granted class moves past the granted bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_ref <= '0;
            ptr_pre <= '0;
            ptr_cas <= '0;
            ptr_act <= '0;
        end else begin
            if (sel_type == CMD_REF) ptr_ref <= sel_bank + BA_W'(1);
            if (sel_type == CMD_PRE) ptr_pre <= sel_bank + BA_W'(1);
            if (sel_type == CMD_RD || sel_type == CMD_WR) ptr_cas <= sel_bank + BA_W'(1);
            if (sel_type == CMD_ACT) ptr_act <= sel_bank + BA_W'(1);
        end
    end

    // Issued-command register: fields captured from the granted bank, held on idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            cmd_type  <= CMD_NOP;
            cmd_ba    <= '0;
            cmd_ra    <= '0;
            cmd_ca    <= '0;
            cmd_id    <= '0;
            cmd_len   <= '0;
        end else begin
            cmd_valid <= (sel_type != CMD_NOP);
            cmd_type  <= sel_type;
            if (sel_type != CMD_NOP) begin
                cmd_ba  <= sel_bank;
                cmd_ra  <= ra[sel_bank*RA_W +: RA_W];
                cmd_ca  <= ca[sel_bank*CA_W +: CA_W];
                cmd_id  <= id[sel_bank*ID_W +: ID_W];
                cmd_len <= len[sel_bank*LEN_W +: LEN_W];
            end
        end
    end

endmodule

// File: tb/tb_sal_cmd_sched.sv
// Self-checking bench for sal_cmd_sched: directed scenarios plus a random
// phase, with a scoreboard predicting the registered command output.
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 2
`endif
`ifndef DRAM_RA_WIDTH
`define DRAM_RA_WIDTH 14
`endif
`ifndef DRAM_CA_WIDTH
`define DRAM_CA_WIDTH 10
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef T_RRD_WIDTH
`define T_RRD_WIDTH 4
`endif
`ifndef T_CCD_WIDTH
`define T_CCD_WIDTH 4
`endif
`ifndef T_WTR_WIDTH
`define T_WTR_WIDTH 4
`endif
`ifndef T_RTW_WIDTH
`define T_RTW_WIDTH 4
`endif

module tb_sal_cmd_sched;
    localparam int NB    = 4;
    localparam int BA_W  = `DRAM_BA_WIDTH;
    localparam int RA_W  = `DRAM_RA_WIDTH;
    localparam int CA_W  = `DRAM_CA_WIDTH;
    localparam int ID_W  = `AXI_ID_WIDTH;
    localparam int LEN_W = `AXI_LEN_WIDTH;

    typedef struct packed {
        logic             v;
        logic [2:0]       t;
        logic [BA_W-1:0]  ba;
        logic [RA_W-1:0]  ra;
        logic [CA_W-1:0]  ca;
        logic [ID_W-1:0]  id;
        logic [LEN_W-1:0] len;
    } cmd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst;
    logic [NB-1:0]           act_r, rd_r, wr_r, pre_r, ref_r;
    logic [NB*RA_W-1:0]      ra_r;
    logic [NB*CA_W-1:0]      ca_r;
    logic [NB*ID_W-1:0]      id_r;
    logic [NB*LEN_W-1:0]     len_r;
    logic [NB-1:0]           act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic [`T_RRD_WIDTH-1:0] t_rrd;
    logic [`T_CCD_WIDTH-1:0] t_ccd;
    logic [`T_WTR_WIDTH-1:0] t_wtr;
    logic [`T_RTW_WIDTH-1:0] t_rtw;
    logic                    cmd_valid;
    logic [2:0]              cmd_type;
    logic [BA_W-1:0]         cmd_ba;
    logic [RA_W-1:0]         cmd_ra;
    logic [CA_W-1:0]         cmd_ca;
    logic [ID_W-1:0]         cmd_id;
    logic [LEN_W-1:0]        cmd_len;

    sal_cmd_sched #(.NUM_BANKS(NB)) dut (
        .clk(clk), .rst(rst),
        .act_req(act_r), .rd_req(rd_r), .wr_req(wr_r), .pre_req(pre_r), .ref_req(ref_r),
        .ra(ra_r), .ca(ca_r), .id(id_r), .len(len_r),
        .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
        .t_rrd_m1(t_rrd), .t_ccd_m1(t_ccd), .t_wtr_m1(t_wtr), .t_rtw_m1(t_rtw),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_ba(cmd_ba), .cmd_ra(cmd_ra),
        .cmd_ca(cmd_ca), .cmd_id(cmd_id), .cmd_len(cmd_len)
    );

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   auto_clear = 1'b1;
    cmd_t sbq[$];
    cmd_t held = '0;
    logic [NB-1:0] g_act, g_rd, g_wr, g_pre, g_ref;
    int   last_act = -1000, last_cas = -1000, last_rd = -1000, last_wr = -1000;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare the registered output, inspect this cycle's grants,
    // predict next output, then retire granted requests like a bank controller.
    task automatic step();
        cmd_t o, e;
        logic [5*NB-1:0] all_g, all_q;
        logic [2:0] ty;
        int b;
        @(negedge clk);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            o = {cmd_valid, cmd_type, cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len};
            chk("cmd_out", 64'(o), 64'(e));
        end
        g_act = act_gnt; g_rd = rd_gnt; g_wr = wr_gnt; g_pre = pre_gnt; g_ref = ref_gnt;
        all_g = {g_ref, g_pre, g_rd, g_wr, g_act};
        all_q = {ref_r, pre_r, rd_r, wr_r, act_r};
        chk("onehot", 64'($countones(all_g) <= 1), 64'd1);
        chk("gnt_implies_req", 64'(all_g & ~all_q), 64'd0);
        if (rst) begin
            chk("rst_no_gnt", 64'(all_g), 64'd0);
            held = '0;
            last_act = -1000; last_cas = -1000; last_rd = -1000; last_wr = -1000;
            sbq.push_back('0);
        end else begin
            if (ref_r != 0) chk("ref_first", 64'(|g_ref), 64'd1);
            ty = 3'd0; b = 0;
            for (int i = 0; i < NB; i++) begin
                if (g_act[i]) begin ty = 3'd1; b = i; end
                if (g_rd[i])  begin ty = 3'd2; b = i; end
                if (g_wr[i])  begin ty = 3'd3; b = i; end
                if (g_pre[i]) begin ty = 3'd4; b = i; end
                if (g_ref[i]) begin ty = 3'd5; b = i; end
            end
            if (ty != 3'd0) begin
                held.v   = 1'b1;
                held.t   = ty;
                held.ba  = BA_W'(b);
                held.ra  = ra_r[b*RA_W +: RA_W];
                held.ca  = ca_r[b*CA_W +: CA_W];
                held.id  = id_r[b*ID_W +: ID_W];
                held.len = len_r[b*LEN_W +: LEN_W];
            end else begin
                held.v = 1'b0;
                held.t = 3'd0;
            end
            sbq.push_back(held);
            if (ty == 3'd1) begin
                chk("rrd_spacing", 64'((cyc - last_act) > int'(t_rrd)), 64'd1);
                last_act = cyc;
            end
            if (ty == 3'd2 || ty == 3'd3) begin
                chk("ccd_spacing", 64'((cyc - last_cas) > int'(t_ccd)), 64'd1);
                last_cas = cyc;
            end
            if (ty == 3'd2) begin
                chk("wtr_spacing", 64'((cyc - last_wr) > int'(t_wtr)), 64'd1);
                last_rd = cyc;
            end
            if (ty == 3'd3) begin
                chk("rtw_spacing", 64'((cyc - last_rd) > int'(t_rtw)), 64'd1);
                last_wr = cyc;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        if (auto_clear) begin
            act_r &= ~g_act; rd_r &= ~g_rd; wr_r &= ~g_wr; pre_r &= ~g_pre; ref_r &= ~g_ref;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        act_r = '0; rd_r = '0; wr_r = '0; pre_r = '0; ref_r = '0;
        t_rrd = '0; t_ccd = '0; t_wtr = '0; t_rtw = '0;
        for (int b = 0; b < NB; b++) begin
            ra_r[b*RA_W +: RA_W]    = RA_W'(16'h100 + b);
            ca_r[b*CA_W +: CA_W]    = CA_W'(16'h20 + b);
            id_r[b*ID_W +: ID_W]    = ID_W'(b + 5);
            len_r[b*LEN_W +: LEN_W] = LEN_W'(8'h40 + b);
        end
        @(posedge clk);
        #1;

        // Reset: requests present while rst is high must not be granted.
        act_r = 4'b1111; ref_r = 4'b0100;
        rst = 1'b1;
        step();
        chk("rst_act", 64'(g_act), 64'd0);
        chk("rst_ref", 64'(g_ref), 64'd0);
        act_r = '0; ref_r = '0;
        do_reset();

        // ACT spacing: two banks, tRRD-1 = 3.
        auto_clear = 1'b1;
        t_rrd = 4'd3;
        act_r = 4'b0011;
        step(); chk("rrd_c0", 64'(g_act), 64'b0001);
        step(); chk("rrd_c1", 64'(g_act), 64'b0000);
        step(); chk("rrd_c2", 64'(g_act), 64'b0000);
        step(); chk("rrd_c3", 64'(g_act), 64'b0000);
        step(); chk("rrd_c4", 64'(g_act), 64'b0010);
        step(); chk("rrd_c5", 64'(g_act), 64'b0000);

        // WR then RD: tWTR-1 = 5, tCCD-1 = 1, RD exactly 6 cycles later.
        do_reset();
        t_rrd = 4'd0; t_wtr = 4'd5; t_ccd = 4'd1; t_rtw = 4'd0;
        wr_r = 4'b0100; rd_r = 4'b1000;
        step(); chk("wtr_wr", 64'(g_wr), 64'b0100);
        chk("wtr_rd0", 64'(g_rd), 64'b0000);
        for (int k = 1; k <= 5; k++) begin
            step(); chk("wtr_wait", 64'(g_rd), 64'b0000);
        end
        step(); chk("wtr_rd6", 64'(g_rd), 64'b1000);

        // CAS round-robin with all timing at zero, requests held high.
        do_reset();
        t_rrd = '0; t_ccd = '0; t_wtr = '0; t_rtw = '0;
        auto_clear = 1'b0;
        rd_r = 4'b1111;
        step(); chk("rr_b0", 64'(g_rd), 64'b0001);
        step(); chk("rr_b1", 64'(g_rd), 64'b0010);
        step(); chk("rr_b2", 64'(g_rd), 64'b0100);
        step(); chk("rr_b3", 64'(g_rd), 64'b1000);
        step(); chk("rr_b0_again", 64'(g_rd), 64'b0001);
        rd_r = '0;
        auto_clear = 1'b1;

        // Class priority: REF > PRE > RD > ACT, one per cycle.
        do_reset();
        ref_r = 4'b0010; pre_r = 4'b0100; rd_r = 4'b1000; act_r = 4'b0001;
        step(); chk("prio_ref", 64'(g_ref), 64'b0010);
        step(); chk("prio_pre", 64'(g_pre), 64'b0100);
        step(); chk("prio_rd",  64'(g_rd),  64'b1000);
        step(); chk("prio_act", 64'(g_act), 64'b0001);
        step(); chk("prio_idle", 64'({g_ref, g_pre, g_rd, g_wr, g_act}), 64'd0);

        // Mid-operation reset discards a pending tRRD window.
        do_reset();
        t_rrd = 4'd7;
        act_r = 4'b0011;
        step(); chk("rstmid_g0", 64'(g_act), 64'b0001);
        rst = 1'b1;
        step(); chk("rstmid_rst", 64'(g_act), 64'b0000);
        rst = 1'b0;
        step(); chk("rstmid_post", 64'(g_act), 64'b0010);

        // Random traffic under fixed random timing.
        do_reset();
        auto_clear = 1'b0;
        t_rrd = 4'($urandom_range(0, 7));
        t_ccd = 4'($urandom_range(0, 7));
        t_wtr = 4'($urandom_range(0, 7));
        t_rtw = 4'($urandom_range(0, 7));
        for (int n = 0; n < 10000; n++) begin
            act_r = 4'($urandom);
            rd_r  = 4'($urandom);
            wr_r  = 4'($urandom);
            pre_r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            ref_r = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
            ra_r  = (NB*RA_W)'({$urandom, $urandom});
            ca_r  = (NB*CA_W)'({$urandom, $urandom});
            id_r  = (NB*ID_W)'($urandom);
            len_r = (NB*LEN_W)'($urandom);
            step();
        end
        act_r = '0; rd_r = '0; wr_r = '0; pre_r = '0; ref_r = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
